// File: rtl/gain_mixer.sv
// rtl/gain_mixer.sv - three-band gain apply and saturating mix, latency 2
module gain_mixer #(
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          Gain1,
  input  logic [1:0]          Gain2,
  input  logic [1:0]          Gain3,
  input  logic                DatosListos,
  input  logic signed [W-1:0] band1,
  input  logic signed [W-1:0] band2,
  input  logic signed [W-1:0] band3,
  input  logic                in_valid,
  output logic signed [W-1:0] mix_out,
  output logic                out_valid,
  output logic                sat,
  output logic [5:0]          gains_act
);

  localparam logic [5:0] GAINS_RESET = 6'b10_10_10;
  localparam logic signed [W+2:0] MAX_V = {4'b0000, {(W-1){1'b1}}};
  localparam logic signed [W+2:0] MIN_V = {4'b1111, {(W-1){1'b0}}};

  logic                dl_prev;
  logic                dl_edge;
  logic [5:0]          pend_gains;
  logic                pend;
  logic signed [W:0]   s1_b1;
  logic signed [W:0]   s1_b2;
  logic signed [W:0]   s1_b3;
  logic                s1_valid;
  logic signed [W+2:0] sum;
  logic signed [W-1:0] clip;
  logic                clip_hit;

  // Gain code to scaled band, widened by one bit so x2 never loses the MSB.
  function automatic logic signed [W:0] scale(input logic signed [W-1:0] b, input logic [1:0] g);
    logic signed [W:0] ext;
    ext = {b[W-1], b};
    case (g)
      2'b00:   scale = '0;
      2'b01:   scale = ext >>> 1;
      2'b10:   scale = ext;
      default: scale = {b, 1'b0};
    endcase
  endfunction

  assign dl_edge = DatosListos & ~dl_prev;

  // Capture gains on a DatosListos rising edge; promote them only on an idle cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      dl_prev    <= 1'b0;
      pend_gains <= '0;
      pend       <= 1'b0;
      gains_act  <= GAINS_RESET;
    end else begin
      dl_prev <= DatosListos;
      if (!in_valid && pend) begin
        gains_act <= pend_gains;
        pend      <= 1'b0;
      end
      if (dl_edge) begin
        pend_gains <= {Gain3, Gain2, Gain1};
        pend       <= 1'b1;
      end
    end
  end

  // Stage 1: scale each band with the gains active before this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_b1    <= '0;
      s1_b2    <= '0;
      s1_b3    <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_b1 <= scale(band1, gains_act[1:0]);
        s1_b2 <= scale(band2, gains_act[3:2]);
        s1_b3 <= scale(band3, gains_act[5:4]);
      end
    end
  end

  // Stage 2 combinational: wide sum and clamp to the W-bit signed range.
  always_comb begin
    sum      = {{2{s1_b1[W]}}, s1_b1} + {{2{s1_b2[W]}}, s1_b2} + {{2{s1_b3[W]}}, s1_b3};
    clip     = sum[W-1:0];
    clip_hit = 1'b0;
    if (sum > MAX_V) begin
      clip     = MAX_V[W-1:0];
      clip_hit = 1'b1;
    end else if (sum < MIN_V) begin
      clip     = MIN_V[W-1:0];
      clip_hit = 1'b1;
    end
  end

  // Stage 2 register: mix_out and sat hold between valid samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      mix_out   <= '0;
      out_valid <= 1'b0;
      sat       <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        mix_out <= clip;
        sat     <= clip_hit;
      end
    end
  end

endmodule

// File: tb/tb_gain_mixer.sv
// tb/tb_gain_mixer.sv - scoreboard bench for gain_mixer against an arithmetic model
module tb_gain_mixer;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [1:0]         Gain1 = 2'b10, Gain2 = 2'b10, Gain3 = 2'b10;
  logic               DatosListos = 1'b0;
  logic signed [15:0] band1 = '0, band2 = '0, band3 = '0;
  logic               in_valid = 1'b0;
  logic signed [15:0] mix_out;
  logic               out_valid;
  logic               sat;
  logic [5:0]         gains_act;

  gain_mixer #(.W(16)) dut (
    .clk(clk), .rst(rst), .Gain1(Gain1), .Gain2(Gain2), .Gain3(Gain3),
    .DatosListos(DatosListos), .band1(band1), .band2(band2), .band3(band3),
    .in_valid(in_valid), .mix_out(mix_out), .out_valid(out_valid), .sat(sat),
    .gains_act(gains_act)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   due;
    int   mix;
    logic s;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;

  // model state: gains as integers 0..3 per band
  int   act[3];
  int   pg[3];
  bit   pend_m;
  bit   dlp_m;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint a, input longint e);
    total++;
    if (a == e) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, a, e, cyc);
  endtask

  function automatic int scale_m(input int b, input int g);
    case (g)
      0: return 0;
      1: return (b < 0 && (b % 2) != 0) ? (b / 2 - 1) : (b / 2);
      2: return b;
      default: return 2 * b;
    endcase
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      act[i] = 2;
      pg[i]  = 0;
    end
    pend_m = 0;
    dlp_m  = 0;
  endfunction

  // One input cycle: drive after the edge, update the model for the edge that samples it.
  task automatic step(input bit r, input bit dl, input int g1, input int g2, input int g3,
                      input bit iv, input int b1, input int b2, input int b3);
    exp_t e;
    int   s;
    bit   edge_m;
    @(posedge clk);
    #1;
    rst = r; DatosListos = dl;
    Gain1 = g1[1:0]; Gain2 = g2[1:0]; Gain3 = g3[1:0];
    in_valid = iv; band1 = b1[15:0]; band2 = b2[15:0]; band3 = b3[15:0];
    if (r) begin
      while (q.size() > 0 && q[$].due >= cyc + 1) void'(q.pop_back());
      model_reset();
      return;
    end
    if (iv) begin
      s = scale_m(b1, act[0]) + scale_m(b2, act[1]) + scale_m(b3, act[2]);
      e.due = cyc + 2;
      e.s   = (s > 32767) || (s < -32768);
      e.mix = (s > 32767) ? 32767 : (s < -32768) ? -32768 : s;
      q.push_back(e);
    end
    edge_m = dl && !dlp_m;
    if (!iv && pend_m) begin
      act = pg;
      pend_m = 0;
    end
    if (edge_m) begin
      pg[0] = g1; pg[1] = g2; pg[2] = g3;
      pend_m = 1;
    end
    dlp_m = dl;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 2, 2, 2, 0, 0, 0, 0);
  endtask

  task automatic set_gains(input int g1, input int g2, input int g3);
    step(0, 1, g1, g2, g3, 0, 0, 0, 0);
    step(0, 0, g1, g2, g3, 0, 0, 0, 0);
    idle(1);
  endtask

  function automatic int act_word();
    return (act[2] << 4) | (act[1] << 2) | act[0];
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a sample.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due < cyc) begin
      chk("missing_output_due", cyc, q[0].due);
      void'(q.pop_front());
    end
    if (out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("latency", cyc, e.due);
        chk("mix_out", int'(mix_out), e.mix);
        chk("sat", sat, e.s);
      end
    end
  end

  initial begin
    int rb[3];
    logic [15:0] r16;
    model_reset();
    step(1, 0, 2, 2, 2, 0, 0, 0, 0);
    step(1, 0, 2, 2, 2, 0, 0, 0, 0);
    step(0, 0, 2, 2, 2, 0, 0, 0, 0);
    @(negedge clk);
    chk("reset_mix_out", int'(mix_out), 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_sat", sat, 0);
    chk("reset_gains_act", gains_act, 6'b10_10_10);

    // default gains, plain sum
    step(0, 0, 2, 2, 2, 1, 1000, 2000, 3000);
    idle(3);

    // x2 on all bands saturates both ways, back-to-back
    set_gains(3, 3, 3);
    step(0, 0, 3, 3, 3, 1, 20000, 20000, 20000);
    step(0, 0, 3, 3, 3, 1, -20000, -20000, -20000);
    idle(3);

    // x0.5 floor, mute, x1
    set_gains(1, 0, 2);
    @(negedge clk);
    chk("gains_act_mixed", gains_act, 6'b10_00_01);
    chk("gains_act_model", gains_act, act_word());
    step(0, 0, 1, 0, 2, 1, -3, 5000, 7);
    idle(3);

    // edge coincident with a sample: that sample keeps the old gains
    set_gains(2, 2, 2);
    step(0, 1, 0, 0, 0, 1, 100, 200, 300);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 100, 200, 300);
    idle(3);
    chk("gains_act_muted", gains_act, 6'b00_00_00);

    // long DatosListos hold captures only the edge value
    step(0, 1, 3, 2, 2, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 2, 2, 0, 0, 0, 0);
    idle(2);
    @(negedge clk);
    chk("gains_act_hold", gains_act, 6'b10_10_11);
    step(0, 0, 2, 2, 2, 1, 1000, -1000, 50);
    idle(3);

    // reset mid-flight drops all three samples, then normal operation
    step(0, 0, 2, 2, 2, 1, 11, 22, 33);
    step(1, 0, 2, 2, 2, 1, 11, 22, 33);
    step(1, 0, 2, 2, 2, 1, 11, 22, 33);
    idle(4);
    step(0, 0, 2, 2, 2, 1, -500, 250, 125);
    idle(3);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 3; k++) begin
        r16 = 16'($urandom);
        rb[k] = int'($signed(r16));
      end
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) == 0),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           ($urandom_range(0, 9) < 6), rb[0], rb[1], rb[2]);
    end
    idle(4);
    @(negedge clk);
    chk("gains_act_random_end", gains_act, act_word());
    chk("scoreboard_drained", q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
